// File: rtl/edge_detector_pkg.sv
// Shared types for the edge detector: FSM state encoding and edge-mode codes.
package edge_detector_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b11,
        FALL = 2'b10
    } edge_state_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Mode 3 is unassigned and falls back to rising-edge detection.
    function automatic logic rise_enabled(input int mode);
        return (mode != EDGE_FALL);
    endfunction

    function automatic logic fall_enabled(input int mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_detector_sync.sv
// N-stage flip-flop synchronizer; N=0 passes the input straight through.
module sync_chain #(
    parameter int N = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    if (N == 0) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ reset;
        assign o_q      = i_d;
    end else begin : g_sync
        logic [N-1:0] r_sync;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= i_d;
                for (int i = 1; i < N; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign o_q = r_sync[N-1];
    end

endmodule

// File: rtl/edge_detector.sv
// Level-to-pulse converter: four-state Moore FSM behind an optional synchronizer.
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int EDGE_MODE   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic outedge
);

    localparam logic RISE_EN = rise_enabled(EDGE_MODE);
    localparam logic FALL_EN = fall_enabled(EDGE_MODE);

    logic        w_s;
    logic        w_next_out;
    edge_state_t r_state;
    edge_state_t w_next;
    logic        r_outedge;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (signal),
        .o_q   (w_s)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ZERO:    w_next = w_s ? RISE : ZERO;
            RISE:    w_next = w_s ? ONE  : FALL;
            ONE:     w_next = w_s ? ONE  : FALL;
            FALL:    w_next = w_s ? RISE : ZERO;
            default: w_next = ZERO;
        endcase
    end

    // Decode from the next state so the output is a flop tracking the state.
    always_comb begin
        w_next_out = 1'b0;
        if (w_next == RISE && RISE_EN) begin
            w_next_out = 1'b1;
        end
        if (w_next == FALL && FALL_EN) begin
            w_next_out = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ZERO;
            r_outedge <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_outedge <= w_next_out;
        end
    end

    assign outedge = r_outedge;

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench: five edge_detector configurations share one stimulus.
module tb_edge_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal;
    logic [4:0] outs;
    int         n_chk  = 0;
    int         n_fail = 0;

    // Input levels sampled at each rising edge since reset released.
    logic       hist[$];

    always #5 clk = ~clk;

    // u0: S0/M0  u1: S0/M1  u2: S0/M2  u3: S2/M0  u4: S0/M3
    edge_detector #(.SYNC_STAGES(0), .EDGE_MODE(0)) u0 (
        .clk(clk), .reset(reset), .signal(signal), .outedge(outs[0]));
    edge_detector #(.SYNC_STAGES(0), .EDGE_MODE(1)) u1 (
        .clk(clk), .reset(reset), .signal(signal), .outedge(outs[1]));
    edge_detector #(.SYNC_STAGES(0), .EDGE_MODE(2)) u2 (
        .clk(clk), .reset(reset), .signal(signal), .outedge(outs[2]));
    edge_detector #(.SYNC_STAGES(2), .EDGE_MODE(0)) u3 (
        .clk(clk), .reset(reset), .signal(signal), .outedge(outs[3]));
    edge_detector #(.SYNC_STAGES(0), .EDGE_MODE(3)) u4 (
        .clk(clk), .reset(reset), .signal(signal), .outedge(outs[4]));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
        end else begin
            hist.push_back(signal);
            if (hist.size() > 16) begin
                void'(hist.pop_front());
            end
        end
    end

    // Level seen by the FSM 'back' edges ago; zero before reset release.
    function automatic logic samp(input int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx >= 0) ? hist[idx] : 1'b0;
    endfunction

    // A pulse follows a change between the two most recent FSM samples.
    function automatic logic exp_one(input int stages, input int mode);
        logic cur, prv, r, f;
        cur = samp(stages);
        prv = samp(stages + 1);
        r   = !prv && cur;
        f   = prv && !cur;
        case (mode)
            1:       return f;
            2:       return r || f;
            default: return r;
        endcase
    endfunction

    function automatic logic [4:0] exp_all();
        return {exp_one(0, 3), exp_one(2, 0), exp_one(0, 2),
                exp_one(0, 1), exp_one(0, 0)};
    endfunction

    task automatic cyc(input logic v);
        signal = v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1'b1);
        n_chk++;
        if (outs !== exp_all()) begin
            n_fail++;
            $display("FAIL reset_pre got %b want %b", outs, exp_all());
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (outs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async got %b want 00000", outs);
        end
        @(negedge clk);
        signal = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            n_chk++;
            if (outs !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_release c%0d got %b want 00000", i, outs);
            end
        end
    endtask

    task automatic test_single_rise();
        int cnt;
        cnt = 0;
        cyc(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            cnt += int'(outs[0]);
            n_chk++;
            if (outs !== exp_all()) begin
                n_fail++;
                $display("FAIL single_rise c%0d got %b want %b", i, outs, exp_all());
            end
            n_chk++;
            if (outs[0] !== (i == 0)) begin
                n_fail++;
                $display("FAIL single_rise_pos c%0d got %b want %b", i, outs[0], i == 0);
            end
        end
        n_chk++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL single_rise_width got %0d pulses want 1", cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (outs[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pulse_cut got %b want 0", outs[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1);
        n_chk++;
        if (outs[0] !== 1'b1 || outs !== exp_all()) begin
            n_fail++;
            $display("FAIL mid_pulse_repulse got %b want %b", outs, exp_all());
        end
        cyc(1'b1);
        n_chk++;
        if (outs[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pulse_single got %b want 0", outs[0]);
        end
    endtask

    task automatic test_fall_mode();
        logic [4:0] seq;
        int         cnt;
        seq = 5'b10011;
        cnt = 0;
        cyc(1'b0);
        cyc(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(seq[i]);
            cnt += int'(outs[1]);
            n_chk++;
            if (outs[1] !== (i == 2) || outs !== exp_all()) begin
                n_fail++;
                $display("FAIL fall_mode c%0d got %b want %b", i, outs, exp_all());
            end
        end
        n_chk++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL fall_mode_count got %0d want 1", cnt);
        end
    endtask

    task automatic test_toggle();
        cyc(1'b0);
        cyc(1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(i % 2 == 0);
            n_chk++;
            if (outs[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL toggle_both c%0d got %b want 1", i, outs[2]);
            end
            n_chk++;
            if (outs[0] !== (i % 2 == 0) || outs !== exp_all()) begin
                n_fail++;
                $display("FAIL toggle_rise c%0d got %b want %b", i, outs, exp_all());
            end
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 4; i++) cyc(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            n_chk++;
            if (outs[3] !== (i == 2) || outs !== exp_all()) begin
                n_fail++;
                $display("FAIL sync_delay c%0d got %b want %b", i, outs, exp_all());
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0);
        #1 signal = 1'b1;
        #2 signal = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            n_chk++;
            if (outs !== 5'b0) begin
                n_fail++;
                $display("FAIL glitch c%0d got %b want 00000", i, outs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                #2 reset = 1'b1;
                #1;
                n_chk++;
                if (outs !== 5'b0) begin
                    n_fail++;
                    $display("FAIL random_reset c%0d got %b want 00000", i, outs);
                end
                @(negedge clk);
                reset = 1'b0;
            end
            cyc(1'($urandom_range(0, 1)));
            n_chk++;
            if (outs !== exp_all()) begin
                n_fail++;
                $display("FAIL random c%0d got %b want %b", i, outs, exp_all());
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        signal = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (outs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state got %b want 00000", outs);
        end
        reset = 1'b0;
        test_reset();
        test_single_rise();
        test_reset_mid_pulse();
        test_fall_mode();
        test_toggle();
        test_sync();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
